// File: rtl/multdiv_wb_scheduler_pkg.sv
// Shared constants, state encoding and decode helpers for the multdiv writeback scheduler.
// Identifies mult/div instructions and the status codes written when an operation faults.
package multdiv_wb_scheduler_pkg;

    localparam logic [4:0]  OPCODE_ALU        = 5'd0;
    localparam logic [4:0]  ALUOP_MULT        = 5'd6;
    localparam logic [4:0]  ALUOP_DIV         = 5'd7;
    localparam logic [31:0] RSTATUS_MULT_CODE = 32'd4;
    localparam logic [31:0] RSTATUS_DIV_CODE  = 32'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        PEND = 2'd2
    } mdState_t;

    function automatic logic isMultOp(input logic [4:0] opcode, input logic [4:0] aluop);
        return (opcode == OPCODE_ALU) && (aluop == ALUOP_MULT);
    endfunction

    function automatic logic isDivOp(input logic [4:0] opcode, input logic [4:0] aluop);
        return (opcode == OPCODE_ALU) && (aluop == ALUOP_DIV);
    endfunction

    // The latched instruction is always mult or div, so the aluop alone picks the code.
    function automatic logic [31:0] excCode(input logic [4:0] aluop);
        return (aluop == ALUOP_DIV) ? RSTATUS_DIV_CODE : RSTATUS_MULT_CODE;
    endfunction

endpackage

// File: rtl/multdiv_wb_scheduler_hazard_detect.sv
// Combinational RAW/WAW compare of the FD-stage register fields against the pending multdiv destination.
// Register 0 is never a real destination, so a pending rd of 0 cannot cause a hazard.
module multdiv_hazard_detect (
    input  logic [4:0] readA,
    input  logic [4:0] readB,
    input  logic [4:0] fd_rd,
    input  logic [4:0] pendRd,
    output logic       hazard
);

    logic raw;
    logic waw;

    assign raw    = (readA == pendRd) || (readB == pendRd);
    assign waw    = (fd_rd == pendRd);
    assign hazard = (pendRd != 5'd0) && (raw || waw);

endmodule

// File: rtl/multdiv_wb_scheduler.sv
// Issues mult/div from DX, tracks the in-flight op, and shares the regfile write port with MW.
// MW always owns the write port; a finished multdiv result waits in PEND until MW is quiet.
module multdiv_wb_scheduler
    import multdiv_wb_scheduler_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int RSTATUS = 30
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] DXIR,
    input  logic        dx_valid,
    input  logic [4:0]  readA,
    input  logic [4:0]  readB,
    input  logic [4:0]  fd_rd,
    input  logic [31:0] MWIR,
    input  logic        mw_wE,
    input  logic [31:0] mw_data,
    input  logic [31:0] md_result,
    input  logic        md_ready,
    input  logic        md_exception,
    output logic        ctrl_MULT,
    output logic        ctrl_DIV,
    output logic [31:0] PWIR,
    output logic        stall,
    output logic        wE,
    output logic [4:0]  writeD,
    output logic [31:0] writeData
);

    localparam int              CNT_W       = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [4:0]      RSTATUS_REG = 5'(RSTATUS);

    mdState_t          state;
    logic [CNT_W-1:0]  cycleCount;
    logic [31:0]       heldResult;
    logic              heldExc;

    logic        dxMult;
    logic        dxDiv;
    logic        dxMdOp;
    logic        busyDone;
    logic        doneExc;
    logic        pwFire;
    logic        pwExc;
    logic [31:0] pwData;
    logic [4:0]  pendRd;
    logic        rawWaw;
    logic        unusedMwir;

    assign unusedMwir = ^{MWIR[31:27], MWIR[21:0]};

    assign dxMult = dx_valid && isMultOp(DXIR[31:27], DXIR[6:2]);
    assign dxDiv  = dx_valid && isDivOp(DXIR[31:27], DXIR[6:2]);
    assign dxMdOp = dxMult || dxDiv;

    // Only an idle unit accepts a new op; a busy one holds DX with a structural stall instead.
    assign ctrl_MULT = reset && (state == IDLE) && dxMult;
    assign ctrl_DIV  = reset && (state == IDLE) && dxDiv;

    // A timeout is an exception completion; a real md_ready in the same cycle takes precedence.
    assign busyDone = (state == BUSY) && (md_ready || (cycleCount == CNT_LAST));
    assign doneExc  = md_ready ? md_exception : 1'b1;

    assign pwFire = (busyDone || (state == PEND)) && !mw_wE;
    assign pwExc  = (state == PEND) ? heldExc    : doneExc;
    assign pwData = (state == PEND) ? heldResult : md_result;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        wE        = mw_wE;
        writeD    = MWIR[26:22];
        writeData = mw_data;
        if (pwFire) begin
            if (pwExc) begin
                wE        = 1'b1;
                writeD    = RSTATUS_REG;
                writeData = excCode(PWIR[6:2]);
            end else begin
                wE        = (PWIR[26:22] != 5'd0);
                writeD    = PWIR[26:22];
                writeData = pwData;
            end
        end
    end

    assign pendRd = ((state == PEND) && heldExc) ? RSTATUS_REG : PWIR[26:22];

    multdiv_hazard_detect u_hazard (
        .readA  (readA),
        .readB  (readB),
        .fd_rd  (fd_rd),
        .pendRd (pendRd),
        .hazard (rawWaw)
    );

    // Data hazards clear on the write cycle (regfile bypass); the structural one holds so DX reissues next cycle.
    assign stall = (state != IDLE) && (dxMdOp || (rawWaw && !pwFire));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            PWIR       <= '0;
            cycleCount <= '0;
            heldResult <= '0;
            heldExc    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (dxMdOp) begin
                        PWIR       <= DXIR;
                        cycleCount <= '0;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    if (cycleCount != CNT_MAX) begin
                        cycleCount <= cycleCount + CNT_W'(1);
                    end
                    if (busyDone) begin
                        if (mw_wE) begin
                            heldResult <= md_result;
                            heldExc    <= doneExc;
                            state      <= PEND;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                PEND: begin
                    if (!mw_wE) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv_wb_scheduler.sv
// Self-checking bench for multdiv_wb_scheduler: directed scenarios plus random traffic against an in-flight-op model.
// Two instances (TIMEOUT 64 and 8) share stimulus; only the selected one is released from reset and checked.
module tb_multdiv_wb_scheduler;

    logic        clock = 1'b0;
    logic        rstA, rstB;
    logic [31:0] DXIR;
    logic        dx_valid;
    logic [4:0]  readA, readB, fd_rd;
    logic [31:0] MWIR;
    logic        mw_wE;
    logic [31:0] mw_data, md_result;
    logic        md_ready, md_exception;

    logic        aMULT, aDIV, aStall, aWE, bMULT, bDIV, bStall, bWE;
    logic [31:0] aPWIR, aWData, bPWIR, bWData;
    logic [4:0]  aWD, bWD;

    bit sel;
    logic        oMULT, oDIV, oStall, oWE;
    logic [31:0] oPWIR, oWData;
    logic [4:0]  oWD;

    int nChecks = 0;
    int nFails  = 0;
    int multPulses = 0;

    bit          mInFlight, mHeld, mHeldExc;
    int          mAge;
    logic [31:0] mIr, mHeldVal;

    always #5 clock = ~clock;

    multdiv_wb_scheduler #(.TIMEOUT(64), .RSTATUS(30)) dutA (
        .clock(clock), .reset(rstA), .DXIR(DXIR), .dx_valid(dx_valid),
        .readA(readA), .readB(readB), .fd_rd(fd_rd), .MWIR(MWIR), .mw_wE(mw_wE),
        .mw_data(mw_data), .md_result(md_result), .md_ready(md_ready), .md_exception(md_exception),
        .ctrl_MULT(aMULT), .ctrl_DIV(aDIV), .PWIR(aPWIR), .stall(aStall),
        .wE(aWE), .writeD(aWD), .writeData(aWData)
    );

    multdiv_wb_scheduler #(.TIMEOUT(8), .RSTATUS(30)) dutB (
        .clock(clock), .reset(rstB), .DXIR(DXIR), .dx_valid(dx_valid),
        .readA(readA), .readB(readB), .fd_rd(fd_rd), .MWIR(MWIR), .mw_wE(mw_wE),
        .mw_data(mw_data), .md_result(md_result), .md_ready(md_ready), .md_exception(md_exception),
        .ctrl_MULT(bMULT), .ctrl_DIV(bDIV), .PWIR(bPWIR), .stall(bStall),
        .wE(bWE), .writeD(bWD), .writeData(bWData)
    );

    assign oMULT  = sel ? bMULT  : aMULT;
    assign oDIV   = sel ? bDIV   : aDIV;
    assign oStall = sel ? bStall : aStall;
    assign oWE    = sel ? bWE    : aWE;
    assign oPWIR  = sel ? bPWIR  : aPWIR;
    assign oWD    = sel ? bWD    : aWD;
    assign oWData = sel ? bWData : aWData;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mkOp(input logic [4:0] aluop, input logic [4:0] rd);
        logic [31:0] ir;
        ir        = $urandom;
        ir[31:27] = 5'd0;
        ir[26:22] = rd;
        ir[6:2]   = aluop;
        return ir;
    endfunction

    function automatic logic [31:0] mkOther();
        logic [31:0] ir;
        ir = $urandom;
        if (ir[31:27] == 5'd0 && (ir[6:2] == 5'd6 || ir[6:2] == 5'd7)) ir[6:2] = 5'd1;
        return ir;
    endfunction

    function automatic bit curRst();
        return sel ? rstB : rstA;
    endfunction

    function automatic bit dxIs(input logic [4:0] aluop);
        return dx_valid && DXIR[31:27] == 5'd0 && DXIR[6:2] == aluop;
    endfunction

    function automatic bit completesNow();
        int tmo;
        tmo = sel ? 8 : 64;
        return mInFlight && !mHeld && (md_ready || mAge == tmo - 1);
    endfunction

    task automatic modelClear();
        mInFlight = 0; mHeld = 0; mHeldExc = 0; mAge = 0; mIr = '0; mHeldVal = '0;
    endtask

    // Expected outputs from the current inputs and the model's view of the in-flight op.
    task automatic compareAll();
        bit          live, pwW, exc, eStall;
        logic [31:0] val, eData;
        logic [4:0]  pend, eWD;
        bit          eWE;
        live = curRst();
        if (!live) modelClear();
        pwW  = (completesNow() || mHeld) && !mw_wE;
        exc  = mHeld ? mHeldExc : (md_ready ? md_exception : 1'b1);
        val  = mHeld ? mHeldVal : md_result;
        eWE = mw_wE; eWD = MWIR[26:22]; eData = mw_data;
        if (pwW) begin
            if (exc) begin
                eWE = 1; eWD = 5'd30; eData = (mIr[6:2] == 5'd7) ? 32'd5 : 32'd4;
            end else begin
                eWE = (mIr[26:22] != 0); eWD = mIr[26:22]; eData = val;
            end
        end
        pend   = (mHeld && mHeldExc) ? 5'd30 : mIr[26:22];
        eStall = mInFlight && ((dxIs(5'd6) || dxIs(5'd7)) ||
                 (!pwW && pend != 0 && (readA == pend || readB == pend || fd_rd == pend)));
        chk("ctrl_MULT", 32'(oMULT), 32'(live && !mInFlight && dxIs(5'd6)));
        chk("ctrl_DIV",  32'(oDIV),  32'(live && !mInFlight && dxIs(5'd7)));
        chk("stall", 32'(oStall), 32'(eStall));
        chk("wE", 32'(oWE), 32'(eWE));
        if (eWE || !pwW) begin
            chk("writeD", 32'(oWD), 32'(eWD));
            chk("writeData", oWData, eData);
        end
        chk("PWIR", oPWIR, mIr);
        if (oMULT) multPulses++;
    endtask

    task automatic modelStep();
        if (!curRst()) begin
            modelClear();
        end else if (!mInFlight) begin
            if (dxIs(5'd6) || dxIs(5'd7)) begin
                mInFlight = 1; mIr = DXIR; mAge = 0;
            end
        end else if (mHeld) begin
            if (!mw_wE) begin mInFlight = 0; mHeld = 0; end
        end else if (completesNow()) begin
            if (mw_wE) begin
                mHeld = 1; mHeldVal = md_result; mHeldExc = md_ready ? md_exception : 1'b1;
            end else begin
                mInFlight = 0;
            end
        end else begin
            mAge++;
        end
    endtask

    task automatic tick();
        @(negedge clock);
        compareAll();
        @(posedge clock);
        modelStep();
        #1;
    endtask

    task automatic quiet();
        dx_valid = 0; DXIR = mkOther(); mw_wE = 0; MWIR = $urandom; mw_data = $urandom;
        md_ready = 0; md_exception = 0; md_result = $urandom;
        readA = 0; readB = 0; fd_rd = 0;
    endtask

    logic [31:0] res;

    initial begin
        modelClear();
        sel = 0; rstA = 0; rstB = 0;
        quiet();
        mw_wE = 1; MWIR = 32'h0240_0000; mw_data = 32'hABCD_0123;
        #1;
        chk("rst_wE_follows_mw", 32'(oWE), 32'd1);
        chk("rst_writeD_follows_mw", 32'(oWD), 32'd9);
        chk("rst_stall", 32'(oStall), 32'd0);
        chk("rst_PWIR", oPWIR, 32'd0);
        repeat (2) tick();
        #2 rstA = 1;
        quiet();
        tick();

        // Mult r3 completing after 33 cycles with MW idle.
        multPulses = 0;
        DXIR = mkOp(5'd6, 5'd3); dx_valid = 1;
        tick();
        quiet();
        repeat (32) tick();
        res = $urandom; md_result = res; md_ready = 1;
        #1;
        chk("t1_wE", 32'(oWE), 32'd1);
        chk("t1_writeD", 32'(oWD), 32'd3);
        chk("t1_writeData", oWData, res);
        tick();
        quiet();
        tick();
        chk("t1_mult_pulses", 32'(multPulses), 32'd1);

        // Div r5 finishing while MW writes r7; result waits for a free port.
        DXIR = mkOp(5'd7, 5'd5); dx_valid = 1;
        tick();
        quiet(); readA = 5;
        repeat (4) tick();
        res = $urandom; md_result = res; md_ready = 1;
        mw_wE = 1; MWIR = 32'h01C0_0000; mw_data = 32'h7777_0007;
        #1;
        chk("t2_mw_writeD", 32'(oWD), 32'd7);
        chk("t2_stall_ready", 32'(oStall), 32'd1);
        tick();
        md_ready = 0; md_result = $urandom; mw_wE = 1; mw_data = $urandom;
        tick();
        mw_wE = 0;
        #1;
        chk("t2_pend_writeD", 32'(oWD), 32'd5);
        chk("t2_pend_data", oWData, res);
        chk("t2_stall_drop", 32'(oStall), 32'd0);
        tick();
        quiet();
        tick();

        // Exception completions for div and mult.
        DXIR = mkOp(5'd7, 5'd9); dx_valid = 1;
        tick();
        quiet();
        repeat (3) tick();
        md_ready = 1; md_exception = 1;
        #1;
        chk("t3_div_exc_writeD", 32'(oWD), 32'd30);
        chk("t3_div_exc_data", oWData, 32'd5);
        tick();
        quiet();
        DXIR = mkOp(5'd6, 5'd11); dx_valid = 1;
        tick();
        quiet();
        repeat (2) tick();
        md_ready = 1; md_exception = 1;
        #1;
        chk("t3_mult_exc_data", oWData, 32'd4);
        tick();
        quiet();

        // RAW on r4 and a no-destination op.
        DXIR = mkOp(5'd6, 5'd4); dx_valid = 1;
        tick();
        quiet(); readB = 4;
        #1 chk("t4_raw_stall", 32'(oStall), 32'd1);
        repeat (3) tick();
        md_ready = 1;
        tick();
        quiet();
        DXIR = mkOp(5'd6, 5'd0); dx_valid = 1;
        tick();
        quiet();
        #1 chk("t4_rd0_no_stall", 32'(oStall), 32'd0);
        repeat (2) tick();
        md_ready = 1;
        #1 chk("t4_rd0_no_write", 32'(oWE), 32'd0);
        tick();
        quiet();

        // Second mult held in DX until the first retires.
        DXIR = mkOp(5'd6, 5'd6); dx_valid = 1;
        tick();
        DXIR = mkOp(5'd6, 5'd8); dx_valid = 1;
        #1;
        chk("t5_struct_stall", 32'(oStall), 32'd1);
        chk("t5_no_pulse", 32'(oMULT), 32'd0);
        repeat (3) tick();
        md_ready = 1; md_result = $urandom;
        #1;
        chk("t5_retire_stall", 32'(oStall), 32'd1);
        chk("t5_retire_no_pulse", 32'(oMULT), 32'd0);
        tick();
        md_ready = 0;
        #1;
        chk("t5_reissue_pulse", 32'(oMULT), 32'd1);
        tick();
        quiet();
        repeat (2) tick();
        md_ready = 1;
        tick();
        quiet();

        // TIMEOUT=8 instance: forced exception, then async reset mid-BUSY.
        sel = 1; rstA = 0; modelClear();
        #2 rstB = 1;
        tick();
        DXIR = mkOp(5'd6, 5'd12); dx_valid = 1;
        tick();
        quiet();
        repeat (7) tick();
        #1;
        chk("t6_timeout_wE", 32'(oWE), 32'd1);
        chk("t6_timeout_writeD", 32'(oWD), 32'd30);
        chk("t6_timeout_data", oWData, 32'd4);
        tick();
        DXIR = mkOp(5'd7, 5'd13); dx_valid = 1;
        tick();
        quiet(); readA = 13; mw_wE = 1; MWIR = 32'h0280_0000;
        repeat (3) tick();
        #2 rstB = 0;
        #1;
        chk("t6_rst_stall", 32'(oStall), 32'd0);
        chk("t6_rst_PWIR", oPWIR, 32'd0);
        chk("t6_rst_wE", 32'(oWE), 32'd1);
        chk("t6_rst_writeD", 32'(oWD), 32'd10);
        modelClear();
        tick();
        #2 rstB = 1;
        quiet();
        tick();
        md_ready = 1; md_result = $urandom;
        #1 chk("t6_late_ready_ignored", 32'(oWE), 32'd0);
        tick();
        quiet();

        // Random traffic on the TIMEOUT=64 instance.
        sel = 0; rstB = 0; modelClear();
        #2 rstA = 1;
        for (int i = 0; i < 1500; i++) begin
            int r;
            r = $urandom_range(0, 9);
            dx_valid = ($urandom_range(0, 3) != 0);
            DXIR = (r < 2) ? mkOp(5'd6, 5'($urandom_range(0, 7))) :
                   (r < 4) ? mkOp(5'd7, 5'($urandom_range(0, 7))) : mkOther();
            r = $urandom_range(0, 8); readA = (r == 8) ? 5'd30 : 5'(r);
            r = $urandom_range(0, 8); readB = (r == 8) ? 5'd30 : 5'(r);
            r = $urandom_range(0, 8); fd_rd = (r == 8) ? 5'd30 : 5'(r);
            MWIR = $urandom; mw_wE = 1'($urandom_range(0, 1)); mw_data = $urandom;
            md_result = $urandom;
            md_ready = ($urandom_range(0, 39) == 0);
            md_exception = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/multdiv_wb_scheduler.md
Name: multdiv_wb_scheduler

Overview:
- Sequences the shared multiply/divide unit for the 5-stage pipeline.
- Issues mult/div operations from DX and tracks the in-flight op in the PW latch.
- Arbitrates the single regfile write port between MW writeback and the multdiv result.
- Raises pipeline stalls for structural and RAW/WAW hazards against the pending result.

Parameters:
- TIMEOUT, 64, max cycles in BUSY before a forced exception writeback.
- RSTATUS, 30, register written on mult/div exception.

Ports:
- clock  in  1  pipeline clock
- reset  in  1  asynchronous, active-low reset
- DXIR  in  32  instruction in DX stage
- dx_valid  in  1  DXIR is a live (non-flushed) instruction
- readA  in  5  FD source reg A
- readB  in  5  FD source reg B
- fd_rd  in  5  FD destination reg, 0 if none
- MWIR  in  32  instruction in MW stage
- mw_wE  in  1  MW instruction writes the regfile
- mw_data  in  32  MW writeback data
- md_result  in  32  multdiv result
- md_ready  in  1  multdiv result valid (one-cycle pulse)
- md_exception  in  1  qualifies md_ready
- ctrl_MULT  out  1  start-multiply pulse
- ctrl_DIV  out  1  start-divide pulse
- PWIR  out  32  latched in-flight mult/div instruction
- stall  out  1  freeze PC/FD/DX, bubble into XM
- wE  out  1  regfile write enable
- writeD  out  5  regfile write address
- writeData  out  32  regfile write data

Behaviour:
- Decode: DX op is mult when DXIR[31:27]==0 and DXIR[6:2]==6; div when DXIR[6:2]==7. Issue requires dx_valid.
- FSM states: IDLE, BUSY, PEND.
- IDLE, DX mult/div: pulse ctrl_MULT or ctrl_DIV for exactly one cycle. Latch PWIR<=DXIR, clear the cycle counter, go to BUSY. No stall is generated for the issuing instruction itself.
- BUSY: counter increments each cycle.
  - md_ready with MW not writing: write this cycle, go to IDLE.
  - md_ready while mw_wE: latch result and exception flag, go to PEND.
  - counter==TIMEOUT-1 without md_ready: treat as exception, same arbitration as md_ready.
- PEND: write on the first cycle with mw_wE=0, then go to IDLE.
- An op completing in a cycle with a new DX mult/div issues that new op the following cycle, never the same cycle.
- Write arbitration: MW always wins. PW writes only when mw_wE=0.
  - With MW winning: wE=1, writeD=MWIR[26:22], writeData=mw_data.
  - Normal PW write: writeD=PWIR[26:22], writeData=md_result (or the latched result).
  - Exception PW write: writeD=RSTATUS, writeData=4 for mult, 5 for div.
  - PW write with PWIR[26:22]==0 and no exception: wE=0, state still retires.
- Stall is combinational and asserted in any of these cases:
  - State!=IDLE and DX holds a valid mult/div (structural).
  - State!=IDLE, pending rd!=0, and readA or readB equals rd (RAW).
  - State!=IDLE, pending rd!=0, and fd_rd equals rd (WAW).
  - Pending rd is RSTATUS when an exception is known (PEND), otherwise PWIR[26:22].
  - Stall drops in the cycle the PW write occurs.
- Reset (async, any state, including mid-operation):
  - State IDLE, PWIR=0, counter=0, latched result=0.
  - Outputs: ctrl_MULT=0, ctrl_DIV=0, stall=0.
  - wE/writeD/writeData follow MW.
  - md_ready arriving after reset is ignored (IDLE).
- Counter width: clog2(TIMEOUT)+1. Counter saturates and never wraps.

Decomposition:
- Shared package holds:
  - opcode constants: ALU=0, aluop MULT=6, DIV=7
  - RSTATUS codes 4/5
  - FSM state encoding (2-bit: IDLE=0, BUSY=1, PEND=2)
- One natural sub-module, multdiv_hazard_detect: purely combinational stall compare on readA/readB/fd_rd vs pending rd.

Test Plan:
- Mult r3 issued, md_ready after 33 cycles, mw_wE=0 that cycle:
  - ctrl_MULT high exactly 1 cycle.
  - wE=1, writeD=3, writeData=md_result on the ready cycle.
  - Then IDLE.
- Div r5, md_ready coincides with mw_wE=1 writing r7:
  - Ready cycle writes r7 from MW.
  - First cycle with mw_wE=0 writes r5 with the latched result.
  - Stall holds until that cycle.
- Div with md_exception=1 on ready: writeD=30, writeData=5. For mult: writeData=4.
- Mult r4 in flight; FD reads readB=4 -> stall=1 until the write cycle. readA=readB=fd_rd=0 and rd=0 op -> stall=0.
- Second mult in DX while BUSY: stall=1, no ctrl_MULT pulse; issued one cycle after the first retires.
- TIMEOUT=8, md_ready never arrives: r30 written with 4 on the 8th BUSY cycle. reset low mid-BUSY -> immediate IDLE, PWIR=0, stall=0; a later md_ready produces no write.
